// File: rtl/output_collector.sv
// Serial-to-parallel frame collector: packs numInput beats of a valid/ready
// stream into one wide vector (slot 0 in the LSBs) and flags malformed frames.
module output_collector #(
  parameter int numInput   = 10,
  parameter int inputWidth = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [inputWidth-1:0]          i_data,
  input  logic                           i_valid,
  input  logic                           i_last,
  output logic                           o_ready,
  output logic [numInput*inputWidth-1:0] o_data,
  output logic                           o_data_valid,
  output logic                           o_error
);

  localparam int CNT_W = $clog2(numInput);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(numInput - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_EMIT,
    S_DISCARD
  } state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [inputWidth-1:0]          buf_q [numInput];
  logic [inputWidth-1:0]          buf_d [numInput];
  logic                           err_q, err_d;
  logic                           long_q, long_d;
  logic                           ready_q, ready_d;
  logic [numInput*inputWidth-1:0] data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           error_q, error_d;
  logic                           accept;

  // NOTE: the fill buffer is a reset register file, not a RAM: short frames
  // rely on unwritten slots reading as zero, even after a mid-frame reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      buf_q   <= '{default: '0};
      err_q   <= 1'b0;
      long_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values computed by the comb block.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      long_q  <= long_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = err_q;
    long_d  = long_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    accept  = i_valid & ready_q;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          buf_d[cnt_q] = i_data;
          if (cnt_q == LAST_SLOT) begin
            // Last slot filled: a missing i_last means the frame overran.
            state_d = S_EMIT;
            err_d   = ~i_last;
            long_d  = ~i_last;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (i_last) begin
              state_d = S_EMIT;
              err_d   = 1'b1;
              long_d  = 1'b0;
            end
          end
        end
      end
      S_EMIT: begin
        for (int k = 0; k < numInput; k++) begin
          data_d[k*inputWidth +: inputWidth] = buf_q[k];
        end
        valid_d = 1'b1;
        error_d = err_q;
        buf_d   = '{default: '0};
        cnt_d   = '0;
        state_d = long_q ? S_DISCARD : S_FILL;
      end
      S_DISCARD: begin
        if (accept && i_last) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase

    // Ready is registered, so it tracks the state being entered.
    ready_d = (state_d != S_EMIT);
  end

  assign o_ready      = ready_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_output_collector.sv
// Randomized bench for output_collector: a frame-level reference model
// predicts every emitted vector, its error flag and its cycle of arrival.
module tb_output_collector;

  localparam int NI = 10;
  localparam int IW = 16;
  localparam int W  = NI * IW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [IW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_last = 1'b0;
  logic          o_ready;
  logic [W-1:0]  o_data;
  logic          o_data_valid;
  logic          o_error;

  output_collector #(.numInput(NI), .inputWidth(IW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_last      (i_last),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_error     (o_error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames are lists of accepted beats.
  typedef struct {
    logic [W-1:0] data;
    bit           err;
    int           cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] m_slots[$];
  bit            m_discard = 1'b0;
  logic [W-1:0]  last_data = '0;
  logic [IW-1:0] fq[$];

  task automatic model_beat(input logic [IW-1:0] d, input logic l, input int acc);
    exp_t e;
    if (m_discard) begin
      if (l) m_discard = 1'b0;
      return;
    end
    m_slots.push_back(d);
    if (m_slots.size() == NI || l) begin
      e.data = '0;
      for (int k = 0; k < m_slots.size(); k++) e.data[k*IW +: IW] = m_slots[k];
      e.err = !(l && m_slots.size() == NI);
      e.cyc = acc + 1;
      if (m_slots.size() == NI && !l) m_discard = 1'b1;
      exp_q.push_back(e);
      m_slots.delete();
    end
  endtask

  task automatic model_reset();
    m_slots.delete();
    m_discard = 1'b0;
    exp_q.delete();
    last_data = '0;
  endtask

  // Called just after a falling edge; holds the beat until accepted.
  task automatic send_beat(input logic [IW-1:0] d, input logic l, output int acc);
    int budget = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    acc     = -1;
    while (acc < 0) begin
      if (o_ready) begin
        acc = cyc + 1;
        model_beat(d, l, acc);
      end else if (budget++ > 20) begin
        check("ready_timeout", 0, 1);
        acc = 0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      i_data = IW'($urandom);
      i_last = 1'($urandom);
      @(negedge CLK);
    end
    i_last = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, output int first_acc, output int last_acc);
    int acc;
    for (int i = 0; i < fq.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send_beat(fq[i], i == fq.size() - 1, acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
  endtask

  task automatic drain();
    int b = 0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    while (exp_q.size() != 0 && b < 40) begin
      @(negedge CLK);
      b++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge CLK);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_valid"}, o_data_valid, 0);
    check({tag, "_error"}, o_error, 0);
  endtask

  // Output monitor: sampled on the falling edge.
  exp_t m_e;
  always @(negedge CLK) begin
    if (!RST) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("missing_pulse", 0, 1);
        void'(exp_q.pop_front());
      end
      if (o_data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          check("pulse_cycle", cyc, m_e.cyc);
          check("frame_data", o_data, m_e.data);
          check("frame_err", o_error, m_e.err);
        end
        last_data = o_data;
      end else begin
        check("hold_data", o_data, last_data);
        check("err_no_valid", o_error, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa, la, fb, lb, acc, best;

    // Reset state and ready release timing.
    #1 check_outputs_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("ready_before_edge", o_ready, 0);
    @(negedge CLK);
    check("ready_after_release", o_ready, 1);

    // Well-formed frame 0x0010..0x00A0.
    fq.delete();
    for (int i = 1; i <= NI; i++) fq.push_back(IW'(16 * i));
    send_frame(1'b0, fa, la);
    i_valid = 1'b0;
    check("ready_low_emit", o_ready, 0);
    @(negedge CLK);
    check("ready_back", o_ready, 1);
    check("slot0", o_data[15:0], 16'h0010);
    check("slot9", o_data[159:144], 16'h00A0);
    drain();

    // Short frame 1..4.
    fq = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_frame(1'b0, fa, la);
    drain();

    // Minimum frame: single beat with i_last.
    fq = '{16'hBEEF};
    send_frame(1'b0, fa, la);
    drain();

    // Long frame of 13 beats, then a well-formed frame.
    fq.delete();
    for (int i = 1; i <= 13; i++) fq.push_back(IW'(16'h0100 + i));
    send_frame(1'b0, fa, la);
    fq.delete();
    for (int i = 0; i < NI; i++) fq.push_back(IW'($urandom));
    send_frame(1'b0, fa, la);
    drain();

    // Valid held high across two back-to-back frames.
    fq.delete();
    for (int i = 0; i < NI; i++) fq.push_back(IW'($urandom));
    send_frame(1'b0, fa, la);
    fq.delete();
    for (int i = 0; i < NI; i++) fq.push_back(IW'($urandom));
    send_frame(1'b0, fb, lb);
    check("b2b_first_beat", fb - la, 2);
    check("b2b_throughput", lb - la, NI + 1);
    drain();

    // Asynchronous reset after 5 beats, then a short frame must not see them.
    for (int i = 0; i < 5; i++) send_beat(16'hF000 | IW'(i + 1), 1'b0, acc);
    i_valid = 1'b0;
    #2 RST = 1'b1;
    model_reset();
    #1 check_outputs_zero("async_reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("ready_rst_release", o_ready, 0);
    @(negedge CLK);
    check("ready_rst_edge", o_ready, 1);
    fq = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
    send_frame(1'b0, fa, la);
    drain();

    // Integration: argmax of the emitted frame with 0x7FFF in slot 6.
    fq.delete();
    for (int i = 0; i < NI; i++) fq.push_back(i == 6 ? 16'h7FFF : IW'($urandom_range(0, 16'h7FFE)));
    fq[2] = 16'h8000;
    send_frame(1'b1, fa, la);
    drain();
    best = 0;
    for (int k = 1; k < NI; k++) begin
      if ($signed(last_data[k*IW +: IW]) > $signed(last_data[best*IW +: IW])) best = k;
    end
    check("argmax", best, 6);

    // Random frames: well-formed, short and long, with and without gaps.
    for (int f = 0; f < 30; f++) begin
      int kind, len;
      kind = $urandom_range(0, 2);
      len  = (kind == 0) ? NI : (kind == 1) ? $urandom_range(1, NI - 1) : $urandom_range(NI + 1, NI + 4);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(IW'($urandom));
      send_frame(bit'($urandom_range(0, 1)), fa, la);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
